// File: rtl/usb_ahb_lite_master_if.sv
// usb_ahb_lite_master_if: command/response and AHB-Lite bundle for usb_ahb_lite_master.
//   cmd_*  : command handshake (valid/ready) carrying write, addr, size, wdata
//   rsp_*  : one-cycle response pulse with right-justified read data and error flag
//   h*     : AHB-Lite master signals toward the endpoint slave port
// Modports: master (the bridge), slave (the command source plus the AHB slave side).
interface usb_ahb_lite_master_if #(parameter int ADDR_W = 4) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_size;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [1:0]        hsize;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hresp;
    logic              hready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hresp, hready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output hsel, haddr, htrans, hsize, hwrite, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hresp, hready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  hsel, haddr, htrans, hsize, hwrite, hwdata
    );
endinterface

// File: rtl/usb_ahb_lite_master.sv
// usb_ahb_lite_master: single-transfer AHB-Lite master for the USB endpoint register port.
//   clk   : system clock, all state on rising edge
//   n_rst : asynchronous active-low reset
//   bus   : usb_ahb_lite_master_if.master (command, response and AHB-Lite signals)
// Commands pass through an address-phase (AP) and a data-phase (DP) register stage;
// a response pulse follows each data-phase completion, in command order.
module usb_ahb_lite_master #(parameter int ADDR_W = 4) (
    input logic                  clk,
    input logic                  n_rst,
    usb_ahb_lite_master_if.master bus
);
    logic              ap_valid, ap_bad, ap_write;
    logic [ADDR_W-1:0] ap_addr;
    logic [1:0]        ap_size;
    logic [31:0]       ap_data;
    logic              dp_valid, dp_bad, dp_write;
    logic [ADDR_W-1:0] dp_addr;
    logic [1:0]        dp_size;
    logic [31:0]       dp_data;
    logic              rsp_valid, rsp_error;
    logic [31:0]       rsp_rdata;
    logic              ready, accept, done, cmd_bad, sel;
    logic [31:0]       lanes, rd_ext;

    assign ready   = !ap_valid || bus.hready;
    assign accept  = bus.cmd_valid && ready;
    assign done    = dp_valid && bus.hready;
    assign sel     = ap_valid && !ap_bad;

    always_comb begin
        cmd_bad = bus.cmd_size == 2'd3 ||
                  (bus.cmd_size == 2'd1 && bus.cmd_addr[0]) ||
                  (bus.cmd_size == 2'd2 && bus.cmd_addr[1:0] != 2'b00);
        lanes   = bus.cmd_size == 2'd0 ? {4{bus.cmd_wdata[7:0]}} :
                  bus.cmd_size == 2'd1 ? {2{bus.cmd_wdata[15:0]}} : bus.cmd_wdata;
        rd_ext  = dp_size == 2'd0 ? {24'd0, bus.hrdata[{dp_addr[1:0], 3'b000} +: 8]} :
                  dp_size == 2'd1 ? {16'd0, bus.hrdata[{dp_addr[1], 4'b0000} +: 16]} : bus.hrdata;
    end

    assign bus.cmd_ready = ready;
    assign bus.hsel      = sel;
    assign bus.htrans    = sel ? 2'b10 : 2'b00;
    assign bus.haddr     = ap_addr;
    assign bus.hsize     = ap_size;
    assign bus.hwrite    = ap_write;
    assign bus.hwdata    = dp_data;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_error = rsp_error;
    assign bus.rsp_rdata = rsp_rdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ap_valid  <= 1'b0;
            ap_bad    <= 1'b0;
            ap_write  <= 1'b0;
            ap_addr   <= '0;
            ap_size   <= 2'd0;
            ap_data   <= 32'd0;
            dp_valid  <= 1'b0;
            dp_bad    <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= '0;
            dp_size   <= 2'd0;
            dp_data   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            if (bus.hready) begin
                dp_valid <= ap_valid;
                dp_bad   <= ap_bad;
                dp_write <= ap_write;
                dp_addr  <= ap_addr;
                dp_size  <= ap_size;
                dp_data  <= ap_data;
            end
            // An empty AP may load even during a wait; the loaded transfer is then
            // simply held on the bus until hready releases it into the data phase.
            if (accept) begin
                ap_valid <= 1'b1;
                ap_bad   <= cmd_bad;
                ap_write <= bus.cmd_write;
                ap_addr  <= bus.cmd_addr;
                ap_size  <= bus.cmd_size;
                ap_data  <= lanes;
            end else if (bus.hready) begin
                ap_valid <= 1'b0;
            end
            rsp_valid <= done;
            rsp_error <= done && (bus.hresp || dp_bad);
            rsp_rdata <= (done && !bus.hresp && !dp_bad && !dp_write) ? rd_ext : 32'd0;
        end
    end
endmodule

// File: tb/tb_usb_ahb_lite_master.sv
// tb_usb_ahb_lite_master: directed stimulus plus a transaction-level model of usb_ahb_lite_master.
// The model keeps outstanding commands in a queue and derives bus fields, lane data,
// extracted read data and responses arithmetically; a negedge process compares every cycle.
module tb_usb_ahb_lite_master;
    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [1:0]  s;
        logic [31:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    usb_ahb_lite_master_if #(.ADDR_W(4)) bus ();

    usb_ahb_lite_master #(.ADDR_W(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cmd_t        q[$];
    int          dp_n = 0;
    int          m_ap_n;
    bit          m_acc;
    cmd_t        m_c;
    bit          e_rv = 1'b0;
    bit          e_re = 1'b0;
    logic [31:0] e_rd = 32'd0;
    int          k_ap_n;

    function automatic bit is_bad(input logic [3:0] a, input logic [1:0] s);
        return s == 2'd3 || (int'(a) % (1 << s)) != 0;
    endfunction

    function automatic logic [31:0] lanes_of(input logic [31:0] d, input logic [1:0] s);
        return s == 2'd0 ? (d & 32'hFF) * 32'h01010101 :
               s == 2'd1 ? (d & 32'hFFFF) * 32'h00010001 : d;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] r, input logic [3:0] a, input logic [1:0] s);
        logic [63:0] mask;
        logic [63:0] sh;
        mask = (64'd1 << (8 << s)) - 64'd1;
        sh   = 64'(r) >> (8 * (int'(a) % 4));
        return 32'(sh & mask);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: commands outstanding in order; dp_n says whether the head is in its data phase.
    initial forever begin
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            q.delete();
            dp_n = 0;
            e_rv = 1'b0;
            e_re = 1'b0;
            e_rd = 32'd0;
        end else begin
            m_ap_n = q.size() - dp_n;
            m_acc  = bus.cmd_valid && (m_ap_n == 0 || bus.hready);
            e_rv   = 1'b0;
            if (bus.hready) begin
                if (dp_n != 0) begin
                    m_c  = q.pop_front();
                    e_rv = 1'b1;
                    e_re = bus.hresp || is_bad(m_c.a, m_c.s);
                    e_rd = (m_c.w || e_re) ? 32'd0 : extract(bus.hrdata, m_c.a, m_c.s);
                end
                dp_n = m_ap_n;
            end
            if (m_acc)
                q.push_back(cmd_t'{bus.cmd_write, bus.cmd_addr, bus.cmd_size, bus.cmd_wdata});
        end
    end

    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            chk("rst_hsel", 32'(bus.hsel), 32'd0);
            chk("rst_htrans", 32'(bus.htrans), 32'd0);
            chk("rst_haddr", 32'(bus.haddr), 32'd0);
            chk("rst_hsize", 32'(bus.hsize), 32'd0);
            chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
            chk("rst_hwdata", bus.hwdata, 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        end else begin
            k_ap_n = q.size() - dp_n;
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(k_ap_n == 0 || bus.hready));
            if (k_ap_n != 0) begin
                m_c = q[dp_n];
                chk("hsel", 32'(bus.hsel), 32'(!is_bad(m_c.a, m_c.s)));
                chk("htrans", 32'(bus.htrans), is_bad(m_c.a, m_c.s) ? 32'd0 : 32'd2);
                chk("haddr", 32'(bus.haddr), 32'(m_c.a));
                chk("hsize", 32'(bus.hsize), 32'(m_c.s));
                chk("hwrite", 32'(bus.hwrite), 32'(m_c.w));
            end else begin
                chk("hsel_idle", 32'(bus.hsel), 32'd0);
                chk("htrans_idle", 32'(bus.htrans), 32'd0);
            end
            if (dp_n != 0 && q[0].w && !is_bad(q[0].a, q[0].s))
                chk("hwdata", bus.hwdata, lanes_of(q[0].d, q[0].s));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            if (e_rv) begin
                chk("rsp_error", 32'(bus.rsp_error), 32'(e_re));
                chk("rsp_rdata", bus.rsp_rdata, e_rd);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input bit cv, input bit w, input logic [3:0] a, input logic [1:0] s,
                       input logic [31:0] wd, input bit hr, input bit hp, input logic [31:0] rd);
        bus.cmd_valid = cv;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = wd;
        bus.hready    = hr;
        bus.hresp     = hp;
        bus.hrdata    = rd;
    endtask

    task automatic t(input bit cv, input bit w, input logic [3:0] a, input logic [1:0] s,
                     input logic [31:0] wd, input bit hr, input bit hp, input logic [31:0] rd);
        drv(cv, w, a, s, wd, hr, hp, rd);
        cyc();
    endtask

    task automatic idle(input logic [31:0] rd);
        t(0, 0, 4'h0, 2'd0, 32'd0, 1, 0, rd);
    endtask

    logic [37:0] tbl [5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drv(0, 0, 4'h0, 2'd0, 32'd0, 1, 0, 32'd0);
        #1;
        chk("init_hsel", 32'(bus.hsel), 32'd0);
        chk("init_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("init_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) cyc();
        n_rst = 1'b1;

        t(1, 1, 4'h4, 2'd2, 32'hDEADBEEF, 1, 0, 32'd0);
        chk("w_htrans", 32'(bus.htrans), 32'd2);
        chk("w_haddr", 32'(bus.haddr), 32'd4);
        chk("w_hsize", 32'(bus.hsize), 32'd2);
        chk("w_hwrite", 32'(bus.hwrite), 32'd1);
        idle(32'd0);
        chk("w_hwdata", bus.hwdata, 32'hDEADBEEF);
        idle(32'd0);
        chk("w_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("w_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("w_rsp_rdata", bus.rsp_rdata, 32'd0);

        t(1, 0, 4'h5, 2'd0, 32'd0, 1, 0, 32'd0);
        idle(32'd0);
        idle(32'h0000AB00);
        chk("rb_rdata", bus.rsp_rdata, 32'h000000AB);
        chk("rb_error", 32'(bus.rsp_error), 32'd0);
        t(1, 1, 4'h0, 2'd0, 32'h0000005A, 1, 0, 32'd0);
        idle(32'd0);
        chk("wb_hwdata", bus.hwdata, 32'h5A5A5A5A);
        idle(32'd0);

        t(1, 0, 4'h8, 2'd2, 32'd0, 1, 0, 32'd0);
        t(1, 0, 4'hC, 2'd2, 32'd0, 1, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 4'h0, 2'd2, 32'h11223344, 0, 0, 32'd0);
            #1;
            chk("wait_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("wait_haddr", 32'(bus.haddr), 32'hC);
            chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
            cyc();
        end
        t(1, 1, 4'h0, 2'd2, 32'h11223344, 1, 0, 32'hCAFEF00D);
        chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wait_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        idle(32'h12345678);
        chk("wait2_rsp_rdata", bus.rsp_rdata, 32'h12345678);
        idle(32'd0);

        t(1, 0, 4'h0, 2'd2, 32'd0, 1, 0, 32'd0);
        t(1, 0, 4'h4, 2'd2, 32'd0, 1, 0, 32'd0);
        t(0, 0, 4'h0, 2'd0, 32'd0, 0, 1, 32'hFFFFFFFF);
        chk("err_hold_haddr", 32'(bus.haddr), 32'd4);
        t(0, 0, 4'h0, 2'd0, 32'd0, 1, 1, 32'hFFFFFFFF);
        chk("err_rsp_error", 32'(bus.rsp_error), 32'd1);
        chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
        idle(32'h0BADF00D);
        chk("err_next_error", 32'(bus.rsp_error), 32'd0);
        chk("err_next_rdata", bus.rsp_rdata, 32'h0BADF00D);

        t(1, 0, 4'h3, 2'd1, 32'd0, 1, 0, 32'd0);
        chk("bad_htrans", 32'(bus.htrans), 32'd0);
        chk("bad_hsel", 32'(bus.hsel), 32'd0);
        t(1, 0, 4'h0, 2'd2, 32'd0, 1, 0, 32'd0);
        chk("bad_next_htrans", 32'(bus.htrans), 32'd2);
        idle(32'h99999999);
        chk("bad_rsp_error", 32'(bus.rsp_error), 32'd1);
        idle(32'h55AA55AA);
        chk("bad_next_rdata", bus.rsp_rdata, 32'h55AA55AA);

        tbl[0] = {1'b0, 4'h2, 1'b1, 32'hBEEF1234};
        tbl[1] = {1'b1, 4'h2, 1'b1, 32'h0000C3D4};
        tbl[2] = {1'b0, 4'h3, 1'b0, 32'h7F000000};
        tbl[3] = {1'b1, 4'h2, 1'b0, 32'h00000000};
        tbl[4] = {1'b0, 4'h6, 1'b0, 32'h00CD0000};
        for (int i = 0; i < 5; i++) begin
            t(1, tbl[i][37], tbl[i][36:33], {1'b0, tbl[i][32]}, tbl[i][31:0], 1, 0, 32'd0);
            idle(32'd0);
            idle(tbl[i][31:0]);
        end
        t(1, 1, 4'h2, 2'd2, 32'h01020304, 1, 0, 32'd0);
        idle(32'd0);
        idle(32'd0);
        chk("mis_word_error", 32'(bus.rsp_error), 32'd1);
        t(1, 0, 4'h0, 2'd3, 32'd0, 1, 0, 32'd0);
        idle(32'd0);
        idle(32'h12345678);
        chk("size3_error", 32'(bus.rsp_error), 32'd1);

        t(1, 0, 4'h0, 2'd2, 32'd0, 1, 0, 32'd0);
        t(1, 0, 4'h4, 2'd2, 32'd0, 1, 0, 32'hA0A0A0A0);
        t(1, 0, 4'h8, 2'd2, 32'd0, 1, 0, 32'hB1B1B1B1);
        t(1, 0, 4'hC, 2'd2, 32'd0, 1, 0, 32'hC2C2C2C2);
        idle(32'hD3D3D3D3);
        idle(32'hE4E4E4E4);
        chk("burst_last_rdata", bus.rsp_rdata, 32'hE4E4E4E4);

        t(1, 0, 4'h4, 2'd2, 32'd0, 1, 0, 32'd0);
        idle(32'd0);
        drv(0, 0, 4'h0, 2'd0, 32'd0, 0, 0, 32'd0);
        cyc();
        #1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_hsel", 32'(bus.hsel), 32'd0);
        chk("mid_rst_htrans", 32'(bus.htrans), 32'd0);
        chk("mid_rst_haddr", 32'(bus.haddr), 32'd0);
        chk("mid_rst_hwdata", bus.hwdata, 32'd0);
        cyc();
        cyc();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(32'hFFFFFFFF);
            chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_ahb_lite_master.md
# usb_ahb_lite_master

AHB-Lite bus master that issues single register transfers to the USB endpoint's AHB-Lite slave port. Test harnesses and the on-chip host controller use it to drive the endpoint's registers and FIFO. A simple command/response interface is turned into pipelined AHB-Lite address and data phases. The block honours slave wait states, handles the two-cycle error response, and returns read data right-justified in command order.

## Interface
- ADDR_W, 4, width of haddr and cmd_addr (endpoint register space)
- clk  in  1  system clock; all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready; combinational, equal to !ap_valid | hready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_size  in  2  0=byte, 1=halfword, 2=word, 3=illegal
- cmd_wdata  in  32  write data, right-justified
- rsp_valid  out  1  one-cycle pulse per command, in command order; no backpressure
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes and errors
- rsp_error  out  1  slave ERROR response or locally rejected command
- hsel  out  1  slave select
- haddr  out  ADDR_W  transfer address
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ; SEQ and BUSY are never driven
- hsize  out  2  transfer size
- hwrite  out  1  transfer direction
- hwdata  out  32  write data (data phase)
- hrdata  in  32  read data from slave
- hresp  in  1  slave error
- hready  in  1  slave ready / transfer done

## Operation
- The pipeline has two register stages. AP (address phase) holds valid, bad, write, addr, size and lane data. DP (data phase) holds the same fields.
- On every clock with hready=1:
  - DP <= AP.
  - AP <= accepted command, or invalid if no command is accepted.
- With hready=0, AP and DP hold. A command is accepted only if AP is empty.
- Bus outputs are driven from the AP registers: hsel=ap_valid&!ap_bad, htrans=NONSEQ when hsel else IDLE, plus haddr, hsize and hwrite. hwdata is driven from the DP lane data.
- Alignment check at acceptance. A command is bad when:
  - size=3, or
  - size=1 and addr[0]=1, or
  - size=2 and addr[1:0]!=0.
- A bad command occupies AP/DP like a normal one but drives IDLE. Its response (rsp_error=1, rsp_rdata=0) therefore stays in order.
- Write lane placement, captured at acceptance:
  - byte: cmd_wdata[7:0] is replicated on all 4 lanes.
  - halfword: cmd_wdata[15:0] is replicated on both halves.
  - word: cmd_wdata is passed through.
- Read extraction:
  - byte: hrdata[8*addr[1:0] +: 8].
  - halfword: hrdata[16*addr[1] +: 16].
  - word: hrdata.
  - The result is zero-extended.
- Data phase completes on the clock where dp_valid=1 and hready=1. On the next cycle the block drives:
  - rsp_valid=1.
  - rsp_error=hresp | dp_bad.
  - rsp_rdata=extracted data, for a read without error; otherwise 0.
- Error response (cycle 1: hresp=1, hready=0; cycle 2: hresp=1, hready=1) is handled as follows:
  - A pending AP transfer is not cancelled.
  - The pending transfer continues with its address held through the wait cycle and issues normally.
  - Each transfer is reported independently.
- hresp sampled while dp_valid=0 is ignored.

## Timing
- Reset values:
  - hsel=0, htrans=2'b00, haddr=0, hsize=0, hwrite=0, hwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - AP and DP invalid, so cmd_ready=1 when hready=1 or the pipeline is empty.
- Latency with zero wait states:
  - Command accepted at edge N.
  - Address phase in cycle N..N+1.
  - Data phase N+1..N+2.
  - rsp_valid in the cycle after edge N+2.
  - Total: 2 cycles from acceptance to the response cycle.
- Each slave wait cycle adds 1 cycle.
- Back-to-back commands sustain 1 transfer per cycle with hready=1. The address phase of command k+1 overlaps the data phase of command k.
- AP outputs stay stable while hready=0. This covers an AHB-legal hold during waits.
- Reset mid-transfer clears all state immediately. Outstanding commands produce no response.
- If a command is accepted in the same cycle as a DP completion, both the shift and the load occur on that edge.

## Test plan
- Write word 0xDEADBEEF to addr 0x4 with hready=1:
  - Next cycle: htrans=10, haddr=4, hsize=2, hwrite=1.
  - Following cycle: hwdata=0xDEADBEEF.
  - Then: rsp_valid=1, rsp_error=0, rsp_rdata=0.
- Read byte at addr 0x5 with hrdata=0x0000AB00 in the data phase:
  - Response: rsp_rdata=0x000000AB, rsp_error=0.
  - Also write byte 0x5A: hwdata=0x5A5A5A5A.
- Read word with hready held low for 3 data-phase cycles:
  - cmd_ready=0 for the second command during the wait.
  - haddr stays stable.
  - rsp_valid arrives 5 cycles after acceptance.
- Two back-to-back reads where the first receives a two-cycle ERROR:
  - First response: rsp_error=1, rsp_rdata=0.
  - Second transfer is issued and responds normally with its hrdata.
- Halfword at addr 0x3, then a word at 0x0:
  - No NONSEQ issued for the first command.
  - Responses in order: error, then normal.
- Assert n_rst during a wait state:
  - All bus outputs go to their reset values immediately.
  - No rsp_valid afterwards.
